// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions used by both the receiver and the transmitter.
// Holds the frame constants, the FSM state type and the bit-period helper.
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam int   STOP_BITS   = 1;
    localparam int   FRAME_BITS  = 1 + DATA_BITS + STOP_BITS;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RESET_VALUE lets an idle-high line come out of reset without a false edge.
module uart_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a half-bit start qualification,
// registered one-cycle rx_valid / rx_frame_error pulses and break hold-off.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | line high, waiting for a low level to begin a frame
// START    | half a bit period in, confirm the start bit is still low
// DATA     | sample one data bit every bit period, LSB first
// STOP     | sample the stop bit; good -> publish byte, bad -> frame error
// BREAK    | line stuck low after a bad stop bit; wait for it to go high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 9600
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_rx,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid,
    output logic                 rx_frame_error,
    output logic                 rx_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_state_t          state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;

    uart_sync #(
        .RESET_VALUE(IDLE_LEVEL)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (serial_rx),
        .q    (rx_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shift_reg      <= '0;
            rx_data_out    <= '0;
            rx_valid       <= 1'b0;
            rx_frame_error <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bit_idx        <= bit_idx_nxt;
            shift_reg      <= shift_nxt;
            rx_data_out    <= data_nxt;
            rx_valid       <= valid_nxt;
            rx_frame_error <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        data_nxt    = rx_data_out;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (rx_s == START_LEVEL) begin
                    state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    state_nxt   = (rx_s == START_LEVEL) ? ST_DATA : ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    // Leaving at mid stop bit leaves half a bit to catch a
                    // back-to-back start edge.
                    if (rx_s == STOP_LEVEL) begin
                        data_nxt  = shift_reg;
                        valid_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_BREAK: begin
                cnt_nxt = '0;
                if (rx_s == IDLE_LEVEL) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced 16 clocks/bit so that the full
// 256-byte sweep stays short; a bench-side serializer drives the line.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_HZ = 160;
    localparam int BAUD   = 10;
    localparam int CPB    = CLK_HZ / BAUD;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       serial_rx = 1'b1;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       rx_frame_error;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    uart_rx #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .BAUD_RATE      (BAUD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .serial_rx     (serial_rx),
        .rx_data_out   (rx_data_out),
        .rx_valid      (rx_valid),
        .rx_frame_error(rx_frame_error),
        .rx_busy       (rx_busy)
    );

    always #5 clock = ~clock;

    // Pulse monitor: counts, captured bytes and pulse-shape violations.
    int         valid_cnt   = 0;
    int         ferr_cnt    = 0;
    int         overlap_cnt = 0;
    int         long_cnt    = 0;
    logic       prev_valid  = 1'b0;
    logic       prev_ferr   = 1'b0;
    logic [7:0] rx_q[$];

    always @(negedge clock) begin
        if (rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            rx_q.push_back(rx_data_out);
        end
        if (rx_frame_error) ferr_cnt <= ferr_cnt + 1;
        if (rx_valid && rx_frame_error) overlap_cnt <= overlap_cnt + 1;
        if ((rx_valid && prev_valid) || (rx_frame_error && prev_ferr)) long_cnt <= long_cnt + 1;
        prev_valid <= rx_valid;
        prev_ferr  <= rx_frame_error;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        serial_rx = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(stop, CPB);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (rx_busy && n < 4 * CPB) begin
            @(negedge clock);
            n++;
        end
        check(name, int'(rx_busy), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_out;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int v0, f0, errs;

        vecs[0] = '{8'h55, 1'b1, 8'h55, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'h80, 1'b1, 8'h80, 1, 0};
        vecs[4] = '{8'h01, 1'b1, 8'h01, 1, 0};
        vecs[5] = '{8'hC4, 1'b0, 8'h01, 0, 1};
        vecs[6] = '{8'h3C, 1'b1, 8'h3C, 1, 0};

        @(negedge clock);
        reset = 1'b1;
        serial_rx = 1'b1;
        repeat (4) @(negedge clock);
        check("reset_data", int'(rx_data_out), 0);
        check("reset_valid", int'(rx_valid), 0);
        check("reset_ferr", int'(rx_frame_error), 0);
        check("reset_busy", int'(rx_busy), 0);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clock);

        for (int k = 0; k < 7; k++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[k].data, vecs[k].stop);
            if (!vecs[k].stop) begin
                hold(1'b0, 2 * CPB);
                check($sformatf("vec%0d_break_busy", k), int'(rx_busy), 1);
            end
            hold(1'b1, CPB);
            wait_idle($sformatf("vec%0d_idle", k));
            check($sformatf("vec%0d_valid", k), valid_cnt - v0, vecs[k].exp_valid);
            check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_data", k), int'(rx_data_out), int'(vecs[k].exp_out));
        end

        // Back-to-back frames with no idle gap between stop and start.
        rx_q.delete();
        f0 = ferr_cnt;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        hold(1'b1, CPB);
        wait_idle("b2b_idle");
        check("b2b_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_first", int'(rx_q[0]), 'hA3);
            check("b2b_second", int'(rx_q[1]), 'h0F);
        end
        check("b2b_ferr", ferr_cnt - f0, 0);

        // Short low glitch: must be rejected at the half-bit check.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        serial_rx = 1'b0;
        repeat (4) @(negedge clock);
        serial_rx = 1'b1;
        repeat (3) @(negedge clock);
        check("glitch_busy", int'(rx_busy), 1);
        hold(1'b1, CPB);
        wait_idle("glitch_idle");
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);

        // One-cycle reset in the middle of data bit 4 of 0x81.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(((8'h81 >> i) & 8'h01) != 0, CPB);
        hold(1'b0, CPB / 2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        serial_rx = 1'b1;
        check("midrst_data", int'(rx_data_out), 0);
        check("midrst_valid", int'(rx_valid), 0);
        check("midrst_ferr", int'(rx_frame_error), 0);
        check("midrst_busy", int'(rx_busy), 0);
        hold(1'b1, 3 * CPB);
        check("midrst_no_valid", valid_cnt - v0, 0);
        check("midrst_no_ferr", ferr_cnt - f0, 0);
        send_frame(8'h7E, 1'b1);
        hold(1'b1, CPB);
        wait_idle("after_rst_idle");
        check("after_rst_valid", valid_cnt - v0, 1);
        check("after_rst_data", int'(rx_data_out), 'h7E);

        // Full byte sweep with mixed zero and one-bit gaps.
        rx_q.delete();
        f0 = ferr_cnt;
        for (int b = 0; b < 256; b++) begin
            send_frame(8'(b), 1'b1);
            if (b % 3 == 0) hold(1'b1, CPB);
        end
        hold(1'b1, CPB);
        wait_idle("sweep_idle");
        check("sweep_count", rx_q.size(), 256);
        errs = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            if (int'(rx_q[i]) != (i & 255)) errs++;
        end
        check("sweep_order", errs, 0);
        check("sweep_ferr", ferr_cnt - f0, 0);

        check("pulse_overlap", overlap_cnt, 0);
        check("pulse_width", long_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
